// File: rtl/pet_pkg.sv
// Shared definitions for the pet behaviour FSM and the attribute controller.
package pet_pkg;

    localparam int unsigned ESTADO_W = 5;
    localparam int unsigned ATRIB_W  = 8;
    localparam int unsigned IDADE_W  = 16;

    localparam logic [ESTADO_W-1:0] INTRO      = 5'b00000;
    localparam logic [ESTADO_W-1:0] IDLE       = 5'b00001;
    localparam logic [ESTADO_W-1:0] DORMINDO   = 5'b00010;
    localparam logic [ESTADO_W-1:0] COMENDO    = 5'b00100;
    localparam logic [ESTADO_W-1:0] DANDO_AULA = 5'b01000;
    localparam logic [ESTADO_W-1:0] MORTO      = 5'b10000;

    localparam logic [ATRIB_W-1:0] MAX_ATRIB = 8'd100;

    typedef enum logic [ESTADO_W-1:0] {
        S_INTRO      = INTRO,
        S_IDLE       = IDLE,
        S_DORMINDO   = DORMINDO,
        S_COMENDO    = COMENDO,
        S_DANDO_AULA = DANDO_AULA,
        S_MORTO      = MORTO
    } estado_t;

    typedef struct packed {
        logic [ATRIB_W-1:0] fome;
        logic [ATRIB_W-1:0] felicidade;
        logic [ATRIB_W-1:0] sono;
    } atrib_t;

    // Values above 100 count as full rather than wrapping.
    function automatic logic atrib_cheio(input logic [ATRIB_W-1:0] a);
        return a >= MAX_ATRIB;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector; history resets to 1 so a level held through reset never fires.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic sinal,
    output logic pulso_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= sinal;
        end
    end

    assign pulso_c = sinal & ~prev;

endmodule

// File: rtl/controlador_estados.sv
// Pet behaviour FSM: buttons and attributes in, one-hot estado, age and death pulse out.
// Optional MORTE_TOLERANCIA_EN: the pet survives GRACE_TICKS-1 ticks with a zero attribute.
module controlador_estados
    import pet_pkg::*;
#(
    parameter int unsigned TICK_W        = 16,
    parameter int unsigned ACT_MAX_TICKS = 20,
    parameter int unsigned GRACE_TICKS   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_start,
    input  logic                btn_dormir,
    input  logic                btn_comer,
    input  logic                btn_aula,
    input  logic [ATRIB_W-1:0]  fome,
    input  logic [ATRIB_W-1:0]  felicidade,
    input  logic [ATRIB_W-1:0]  sono,
    output logic [ESTADO_W-1:0] estado,
    output logic [IDADE_W-1:0]  idade,
    output logic                morreu
);

    localparam int unsigned ACT_W = $clog2(ACT_MAX_TICKS + 1);

    estado_t            estado_q, estado_d;
    logic [TICK_W-1:0]  pre_q;
    logic [ACT_W-1:0]   act_q, act_d;
    logic [IDADE_W-1:0] idade_d;
    logic               morreu_d;

    logic p_start, p_dormir, p_comer, p_aula;
    logic tick, vivo, ativ, zero_atrib, morte, fim_timer, entra_ativ;

    detector_borda u_borda_start  (.clk(clk), .rst_n(rst_n), .sinal(btn_start),  .pulso_c(p_start));
    detector_borda u_borda_dormir (.clk(clk), .rst_n(rst_n), .sinal(btn_dormir), .pulso_c(p_dormir));
    detector_borda u_borda_comer  (.clk(clk), .rst_n(rst_n), .sinal(btn_comer),  .pulso_c(p_comer));
    detector_borda u_borda_aula   (.clk(clk), .rst_n(rst_n), .sinal(btn_aula),   .pulso_c(p_aula));

    assign tick       = &pre_q;
    assign ativ       = (estado_q == S_DORMINDO) || (estado_q == S_COMENDO) ||
                        (estado_q == S_DANDO_AULA);
    assign vivo       = ativ || (estado_q == S_IDLE);
    assign zero_atrib = (fome == '0) || (felicidade == '0) || (sono == '0);
    assign fim_timer  = tick && (act_q == ACT_W'(ACT_MAX_TICKS - 1));

`ifdef MORTE_TOLERANCIA_EN
    localparam int unsigned GRACE_W = $clog2(GRACE_TICKS + 1);

    logic [GRACE_W-1:0] grace_q, grace_d;

    // Death happens on the tick that would bring the counter to GRACE_TICKS.
    assign morte = vivo && zero_atrib && tick && (grace_q == GRACE_W'(GRACE_TICKS - 1));

    always_comb begin
        grace_d = grace_q;
        if (!vivo || !zero_atrib || entra_ativ) begin
            grace_d = '0;
        end else if (tick) begin
            grace_d = grace_q + GRACE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grace_q <= '0;
        end else begin
            grace_q <= grace_d;
        end
    end
`else
    logic unused_grace;

    assign morte        = vivo && zero_atrib;
    assign unused_grace = |GRACE_TICKS;
`endif

    // Next state, activity timer, age and death pulse.
    always_comb begin
        estado_d   = estado_q;
        act_d      = act_q;
        idade_d    = idade;
        entra_ativ = 1'b0;

        if (vivo && tick && (idade != '1)) begin
            idade_d = idade + IDADE_W'(1);
        end
        if (ativ && tick) begin
            act_d = act_q + ACT_W'(1);
        end

        case (estado_q)
            S_INTRO: begin
                if (p_start) begin
                    estado_d = S_IDLE;
                    idade_d  = '0;
                end
            end
            S_IDLE: begin
                if (morte) begin
                    estado_d = S_MORTO;
                end else if (p_dormir) begin
                    estado_d   = S_DORMINDO;
                    entra_ativ = 1'b1;
                end else if (p_comer) begin
                    estado_d   = S_COMENDO;
                    entra_ativ = 1'b1;
                end else if (p_aula) begin
                    estado_d   = S_DANDO_AULA;
                    entra_ativ = 1'b1;
                end
            end
            S_DORMINDO: begin
                if (morte) begin
                    estado_d = S_MORTO;
                end else if (atrib_cheio(sono) || p_dormir || fim_timer) begin
                    estado_d = S_IDLE;
                end
            end
            S_COMENDO: begin
                if (morte) begin
                    estado_d = S_MORTO;
                end else if (atrib_cheio(fome) || p_comer || fim_timer) begin
                    estado_d = S_IDLE;
                end
            end
            S_DANDO_AULA: begin
                if (morte) begin
                    estado_d = S_MORTO;
                end else if (atrib_cheio(felicidade) || p_aula || fim_timer) begin
                    estado_d = S_IDLE;
                end
            end
            S_MORTO: begin
                if (p_start) begin
                    estado_d = S_INTRO;
                end
            end
            default: begin
                estado_d = S_INTRO;
            end
        endcase

        if (entra_ativ) begin
            act_d = '0;
        end

        morreu_d = (estado_d == S_MORTO) && (estado_q != S_MORTO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= S_INTRO;
            pre_q    <= '0;
            act_q    <= '0;
            idade    <= '0;
            morreu   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pre_q    <= pre_q + TICK_W'(1);
            act_q    <= act_d;
            idade    <= idade_d;
            morreu   <= morreu_d;
        end
    end

    assign estado = estado_q;

endmodule
